// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared types and default sizing for the up/down counter bank.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NCH   = 4;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_dir_e;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/updown_counter_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_bank_if
// Description : Control/status bundle of the counter bank; slave = the bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface updown_counter_bank_if
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH
);

  logic [NCH-1:0]       count_en;
  logic [NCH-1:0]       up_down;
  logic [NCH-1:0]       load;
  logic [NCH*WIDTH-1:0] in_val;
  logic [NCH*WIDTH-1:0] limit;
  logic [NCH-1:0]       sat_mode;
  logic [NCH*WIDTH-1:0] out_val;
  logic [NCH-1:0]       carry_out;
  logic [NCH-1:0]       at_zero;

  modport master (
    output count_en, up_down, load, in_val, limit, sat_mode,
    input  out_val, carry_out, at_zero
  );

  modport slave (
    input  count_en, up_down, load, in_val, limit, sat_mode,
    output out_val, carry_out, at_zero
  );

endinterface : updown_counter_bank_if
`default_nettype wire

// File: rtl/counter_channel.sv
`default_nettype none
// ============================================================================
// Module      : counter_channel
// Description : One up/down counter with load, runtime limit, wrap/saturate
//               and a registered boundary pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_channel
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             sat,
  input  logic [WIDTH-1:0] in_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] cnt,
  output logic             carry,
  output logic             step_bnd
);

  cnt_dir_e         dir;
  cnt_mode_e        mode;
  logic             at_bnd;
  logic [WIDTH-1:0] cnt_d, cnt_q;
  logic             carry_d, carry_q;

  assign dir  = cnt_dir_e'(up);
  assign mode = cnt_mode_e'(sat);

  always_comb begin
    // >= so a limit lowered beneath the count still registers as the boundary
    at_bnd   = (dir == CNT_UP) ? (cnt_q >= limit) : (cnt_q == '0);
    step_bnd = en & ~load & at_bnd;
    carry_d  = step_bnd;
    cnt_d    = cnt_q;
    if (load) begin
      cnt_d = (in_val > limit) ? limit : in_val;
    end else if (en) begin
      if (at_bnd) begin
        if (mode == CNT_SAT) cnt_d = (dir == CNT_UP) ? limit : '0;
        else                 cnt_d = (dir == CNT_UP) ? '0 : limit;
      end else begin
        cnt_d = (dir == CNT_UP) ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) carry_q <= 1'b0;
    else        carry_q <= carry_d;
  end

  assign cnt   = cnt_q;
  assign carry = carry_q;

endmodule : counter_channel
`default_nettype wire

// File: rtl/updown_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_bank
// Description : NCH independent up/down counters. Define
//               COUNTER_BANK_CASCADE_EN to chain channels into one wide counter.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_bank
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  updown_counter_bank_if.slave  bus
);

  logic [NCH-1:0]       eff_en;
  logic [NCH-1:0]       step_bnd;
  logic [NCH-1:0]       carry_w;
  logic [NCH*WIDTH-1:0] cnt_w;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
`ifdef COUNTER_BANK_CASCADE_EN
    // Ripple enable: a channel only advances when its lower neighbour steps over
    if (i == 0) begin : g_first
      assign eff_en[i] = bus.count_en[i];
    end else begin : g_chain
      assign eff_en[i] = bus.count_en[i] & step_bnd[i-1];
    end
`else
    assign eff_en[i] = bus.count_en[i];
`endif

    counter_channel #(.WIDTH(WIDTH)) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (eff_en[i]),
      .up       (bus.up_down[i]),
      .load     (bus.load[i]),
      .sat      (bus.sat_mode[i]),
      .in_val   (bus.in_val[i*WIDTH +: WIDTH]),
      .limit    (bus.limit[i*WIDTH +: WIDTH]),
      .cnt      (cnt_w[i*WIDTH +: WIDTH]),
      .carry    (carry_w[i]),
      .step_bnd (step_bnd[i])
    );

    assign bus.at_zero[i] = (cnt_w[i*WIDTH +: WIDTH] == '0);
  end

  assign bus.out_val   = cnt_w;
  assign bus.carry_out = carry_w;

endmodule : updown_counter_bank
`default_nettype wire
